// File: rtl/q_inv_layer.sv
// q_inv_layer: iterative inverse-Q nibble substitution on a 64-bit block.
// A block is loaded into a working register, LANES nibbles are substituted
// per BUSY cycle, and the register is rotated right by one lane group each
// cycle. After 16/LANES cycles every nibble has been substituted and is back
// in its original position. The result is then held until downstream takes it.
module q_inv_layer #(
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("q_inv_layer: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int         STEPS = 16 / LANES;
  localparam int         SHIFT = 4 * LANES;
  localparam logic [3:0] LAST  = 4'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] work;
  logic [3:0]  cnt;
  logic [63:0] work_sub;
  logic [63:0] work_next;

  // Inverse Q mapping; it is its own inverse.
  function automatic logic [3:0] qinv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h9;
      4'h1: y = 4'hE;
      4'h2: y = 4'h5;
      4'h3: y = 4'h6;
      4'h4: y = 4'hA;
      4'h5: y = 4'h2;
      4'h6: y = 4'h3;
      4'h7: y = 4'hC;
      4'h8: y = 4'hF;
      4'h9: y = 4'h0;
      4'hA: y = 4'h4;
      4'hB: y = 4'hD;
      4'hC: y = 4'h7;
      4'hD: y = 4'hB;
      4'hE: y = 4'h1;
      default: y = 4'h8;
    endcase
    return y;
  endfunction

  // Substitute the LANES low nibbles, then rotate right by one lane group.
  // With LANES=16 the right shift clears everything and the left shift is
  // zero, so the rotation degenerates to the identity as intended.
  always_comb begin
    work_sub = work;
    for (int i = 0; i < LANES; i++) begin
      work_sub[4*i +: 4] = qinv(work[4*i +: 4]);
    end
    work_next = (work_sub >> SHIFT) | (work_sub << (64 - SHIFT));
  end

  // Control FSM with registered handshake outputs and the working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            work     <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          work <= work_next;
          cnt  <= cnt + 4'd1;
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE first keeps a new block off this same edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = work;

endmodule

// File: tb/tb_q_inv_layer.sv
// Testbench for q_inv_layer: one instance per legal LANES value, directed
// vectors and flow-control scenarios on LANES=4, randomized blocks on all.
module tb_q_inv_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [5];
  logic        in_ready  [5];
  logic [63:0] in_data   [5];
  logic        out_valid [5];
  logic        out_ready [5];
  logic [63:0] out_data  [5];
  logic        busy      [5];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    q_inv_layer #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  // Reference: table lookup per nibble.
  function automatic logic [63:0] ref_model(input logic [63:0] d);
    logic [3:0]  tbl [16] = '{4'h9, 4'hE, 4'h5, 4'h6, 4'hA, 4'h2, 4'h3, 4'hC,
                              4'hF, 4'h0, 4'h4, 4'hD, 4'h7, 4'hB, 4'h1, 4'h8};
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[4*k +: 4] = tbl[d[4*k +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Offer one block to instance i, scramble in_data after acceptance, and
  // wait (bounded) for out_valid. Returns at the negedge where out_valid is seen.
  task automatic run_block(input int i, input logic [63:0] d,
                           output logic [63:0] got, output int lat);
    @(negedge clk);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    in_data[i]  = rand64();
    lat = 1;
    @(negedge clk);
    while (!out_valid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = out_data[i];
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || out_data[i] !== 64'h0) begin
        n_bad++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
                 i, in_ready[i], out_valid[i], busy[i], out_data[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic check_block(input string name, input int i, input logic [63:0] d,
                             input logic [63:0] exp, input int exp_lat);
    logic [63:0] got;
    int lat;
    run_block(i, d, got, lat);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s data: got %h, required %h", name, got, exp);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_vectors;
    check_block("vec_ramp", 2, 64'h0123456789ABCDEF, 64'h9E56A23CF04D7B18, 5);
    check_block("vec_zero", 2, 64'h0, 64'h9999999999999999, 5);
    check_block("vec_ones", 2, 64'hFFFFFFFFFFFFFFFF, 64'h8888888888888888, 5);
    check_block("vec_invol", 2, 64'h9E56A23CF04D7B18, 64'h0123456789ABCDEF, 5);
  endtask

  task automatic test_busy_flag;
    @(negedge clk);
    in_valid[2] = 1'b1; in_data[2] = rand64();
    @(posedge clk); #1 in_valid[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy[2] !== 1'b1 || in_ready[2] !== 1'b0 || out_valid[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_flags: busy=%b in_ready=%b out_valid=%b, required 1 0 0",
               busy[2], in_ready[2], out_valid[2]);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random_all;
    logic [63:0] d, got;
    int lat;
    int bad_here;
    for (int i = 0; i < 5; i++) begin
      bad_here = 0;
      for (int n = 0; n < 1000; n++) begin
        d = rand64();
        run_block(i, d, got, lat);
        n_cmp++;
        if (got !== ref_model(d) || ref_model(got) !== d) begin
          n_bad++; bad_here++;
          if (bad_here < 5)
            $display("FAIL random L=%0d data: in %h got %h, required %h", 1 << i, d, got, ref_model(d));
        end
        n_cmp++;
        if (lat !== 16 / (1 << i) + 1) begin
          n_bad++; bad_here++;
          if (bad_here < 5)
            $display("FAIL random L=%0d latency: got %0d, required %0d", 1 << i, lat, 16 / (1 << i) + 1);
        end
      end
    end
  endtask

  task automatic test_hold;
    logic [63:0] got, exp;
    int lat;
    logic [63:0] d;
    d = rand64();
    exp = ref_model(d);
    out_ready[2] = 1'b0;
    run_block(2, d, got, lat);
    for (int c = 0; c < 10; c++) begin
      in_valid[2] = c[0];
      in_data[2]  = rand64();
      @(negedge clk);
      n_cmp++;
      if (out_data[2] !== exp || out_valid[2] !== 1'b1 || in_ready[2] !== 1'b0) begin
        n_bad++;
        $display("FAIL hold cycle %0d: out_data=%h out_valid=%b in_ready=%b, required %h 1 0",
                 c, out_data[2], out_valid[2], in_ready[2], exp);
      end
    end
    in_valid[2]  = 1'b1;
    out_ready[2] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready[2], out_valid[2], busy[2]);
    end
    in_valid[2] = 1'b0;
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    in_valid[2] = 1'b1; in_data[2] = 64'hFEDCBA9876543210;
    @(posedge clk); #1 in_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0 || busy[2] !== 1'b0 || out_data[2] !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_in_busy: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
               in_ready[2], out_valid[2], busy[2], out_data[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_no_partial: out_valid=%b in_ready=%b, required 0 1", out_valid[2], in_ready[2]);
      end
    end
    check_block("after_reset", 2, 64'h0, 64'h9999999999999999, 5);
  endtask

  task automatic test_back_to_back;
    logic [63:0] sent [$];
    int          acc [$];
    logic [63:0] cur, exp;
    logic        took;
    out_ready[2] = 1'b1;
    @(negedge clk);
    cur = rand64();
    in_valid[2] = 1'b1; in_data[2] = cur;
    for (int c = 0; c < 62; c++) begin
      took = 1'b0;
      if (out_valid[2]) begin
        n_cmp++;
        if (sent.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_dup: output %h with nothing outstanding, required none", out_data[2]);
        end else begin
          exp = ref_model(sent.pop_front());
          if (out_data[2] !== exp) begin
            n_bad++;
            $display("FAIL b2b_data: got %h, required %h", out_data[2], exp);
          end
        end
      end
      if (in_ready[2]) begin
        sent.push_back(cur);
        acc.push_back(c);
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      if (took) begin
        cur = rand64();
        in_data[2] = cur;
      end
      @(negedge clk);
    end
    in_valid[2] = 1'b0;
    for (int c = 0; c < 20 && sent.size() > 0; c++) begin
      if (out_valid[2]) begin
        exp = ref_model(sent.pop_front());
        n_cmp++;
        if (out_data[2] !== exp) begin
          n_bad++;
          $display("FAIL b2b_drain: got %h, required %h", out_data[2], exp);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (sent.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_lost: %0d blocks outstanding, required 0", sent.size());
    end
    n_cmp++;
    if (acc.size() < 10) begin
      n_bad++;
      $display("FAIL b2b_count: %0d accepts, required at least 10", acc.size());
    end
    for (int k = 1; k < acc.size(); k++) begin
      n_cmp++;
      if (acc[k] - acc[k-1] != 6) begin
        n_bad++;
        $display("FAIL b2b_interval %0d: got %0d cycles, required 6", k, acc[k] - acc[k-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_busy_flag();
    test_hold();
    test_reset_busy();
    test_back_to_back();
    test_random_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/q_inv_layer.md
Q_INV_LAYER -- requirements
Module: q_inv_layer

Interface
REQ-001 Parameter: LANES, default 4, nibbles substituted per clock; legal values 1, 2, 4, 8 and 16; any other value SHALL fail elaboration.
REQ-002 Port: clk  input  1  single clock, rising edge.
REQ-003 Port: rst_n  input  1  asynchronous reset, active-low.
REQ-004 Port: in_valid  input  1  upstream offers a block.
REQ-005 Port: in_ready  output  1  block can accept a block.
REQ-006 Port: in_data  input  64  block to substitute; nibble k is bits [4k+3:4k].
REQ-007 Port: out_valid  output  1  result is available.
REQ-008 Port: out_ready  input  1  downstream accepts the result.
REQ-009 Port: out_data  output  64  substituted block.
REQ-010 Port: busy  output  1  substitution is in progress.

Function
REQ-011 The block SHALL apply the inverse Q nibble mapping independently to each of the 16 nibbles.
REQ-012 Mapping in->out SHALL be: 0->9, 1->E, 2->5, 3->6, 4->A, 5->2, 6->3, 7->C, 8->F, 9->0, A->4, B->D, C->7, D->B, E->1, F->8.
REQ-013 The mapping SHALL be an involution; applying it twice SHALL return the original value.
REQ-014 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 busy SHALL be 1 only in BUSY.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 IDLE -> BUSY on any rising edge with in_valid=1: register in_data into the working register; clear the cycle counter.
REQ-019 In each BUSY cycle, the LANES least-significant working nibbles SHALL be substituted.
REQ-020 After substitution, the working register SHALL rotate right by 4*LANES bits.
REQ-021 BUSY SHALL last exactly 16/LANES cycles; the counter SHALL be 0 .. 16/LANES-1.
REQ-022 On the last BUSY cycle the block SHALL enter DONE.
REQ-023 Latency SHALL be 16/LANES+1 cycles, from the accepting edge to the first cycle with out_valid=1 (default: 5).
REQ-024 After the 16/LANES rotations every nibble SHALL be back at its original position; out_data nibble k SHALL equal Qinv(in_data nibble k).
REQ-025 In DONE, out_data SHALL stay stable until out_ready=1.
REQ-026 DONE -> IDLE on the edge with out_ready=1.
REQ-027 A new block SHALL NOT be accepted on the same edge that leaves DONE; throughput is one block per 16/LANES+2 cycles minimum.
REQ-028 in_valid SHALL be ignored in BUSY and DONE.
REQ-029 in_data changes after acceptance SHALL NOT affect the result.
REQ-030 out_ready SHALL be ignored outside DONE.
REQ-031 out_data SHALL reflect the working register at all times; it is meaningful only when out_valid=1.

Reset
REQ-032 While rst_n=0: state=IDLE, working register=0, counter=0, in_ready=1, out_valid=0, busy=0, out_data=64'h0.
REQ-033 Reset asserted in BUSY or DONE SHALL discard the block immediately; no partial result SHALL be presented after release.
REQ-034 The first acceptance SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-035 in_data=64'h0123456789ABCDEF accepted, out_ready=1 -> out_data=64'h9E56A23CF04D7B18 with out_valid=1 exactly 5 cycles after the accepting edge (LANES=4).
REQ-036 in_data=64'h0 -> out_data=64'h9999999999999999; in_data=64'hFFFFFFFFFFFFFFFF -> 64'h8888888888888888.
REQ-037 Feed 64'h9E56A23CF04D7B18 back in -> out_data=64'h0123456789ABCDEF (involution); repeat over 1000 random blocks for every legal LANES, comparing against a reference model; latency SHALL be 17, 9, 5, 3 and 2 cycles for LANES=1, 2, 4, 8 and 16.
REQ-038 Hold out_ready=0 for 10 cycles in DONE and toggle in_valid/in_data -> out_data and out_valid unchanged, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-039 Assert rst_n=0 for 1 cycle in the 2nd BUSY cycle -> all outputs at reset values immediately; after release, accept 64'h0 -> 64'h9999999999999999.
REQ-040 Hold in_valid=1 continuously with out_ready=1 -> accepts exactly every 16/LANES+2 cycles (6 for LANES=4); no block is lost or duplicated.
